arc_plotter: RTL

Parametrised arc-drawing engine for the 160x120 VGA adapter path; generalises the fixed clear/right/left/top Reuleaux sequencer. It optionally clears the screen, then draws up to N_ARCS circle arcs from a loadable descriptor table. Each arc has a centre, a radius, an 8-bit octant mask and a colour. Off-screen pixels are clipped. The block drives the adapter's x/y/colour/plot inputs and uses the codebase start/done handshake.

---
 rtl/arc_plotter.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/arc_plotter.sv
// arc_plotter: optional full-screen clear followed by up to N_ARCS midpoint
// circle arcs from a loadable descriptor table. Each loop iteration spends 8
// cycles, one per octant, and off-screen points are suppressed rather than
// wrapped.
module arc_plotter #(
  parameter int          N_ARCS    = 8,
  parameter int          SCREEN_W  = 160,
  parameter int          SCREEN_H  = 120,
  parameter int          XW        = 8,
  parameter int          YW        = 7,
  parameter int          RW        = 8,
  parameter logic [2:0]  BG_COLOUR = 3'b000,
  localparam int         AW        = $clog2(N_ARCS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          clear_en,
  input  logic [AW:0]   num_arcs,
  input  logic          arc_we,
  input  logic [AW-1:0] arc_addr,
  input  logic [XW-1:0] arc_cx,
  input  logic [YW-1:0] arc_cy,
  input  logic [RW-1:0] arc_r,
  input  logic [7:0]    arc_mask,
  input  logic [2:0]    arc_colour,
  output logic [XW-1:0] vga_x,
  output logic [YW-1:0] vga_y,
  output logic [2:0]    vga_colour,
  output logic          vga_plot,
  output logic          busy,
  output logic          done
);
  // Signed working width: two bits of headroom so that sums below zero or
  // beyond the coordinate range remain distinguishable.
  localparam int MW = (XW > YW) ? XW : YW;
  localparam int SW = ((MW > RW) ? MW : RW) + 2;

  localparam logic signed [SW-1:0] ONE   = SW'(1);
  localparam logic signed [SW-1:0] LIM_X = SW'(SCREEN_W);
  localparam logic signed [SW-1:0] LIM_Y = SW'(SCREEN_H);
  localparam logic [AW:0]          NMAX  = (AW+1)'(N_ARCS);
  localparam logic [XW-1:0]        LAST_X = XW'(SCREEN_W - 1);
  localparam logic [YW-1:0]        LAST_Y = YW'(SCREEN_H - 1);

  typedef enum logic [2:0] {IDLE, LOAD, CLEAR, ARC_INIT, ARC_RUN, DONE} state_t;
  state_t state, nstate;

  // Descriptor table
  logic [XW-1:0] tab_cx   [N_ARCS];
  logic [YW-1:0] tab_cy   [N_ARCS];
  logic [RW-1:0] tab_r    [N_ARCS];
  logic [7:0]    tab_mask [N_ARCS];
  logic [2:0]    tab_col  [N_ARCS];

  // Job and arc working state
  logic                 clr_q;
  logic [AW:0]          count, idx;
  logic [XW-1:0]        sx;
  logic [YW-1:0]        sy;
  logic [XW-1:0]        cur_cx;
  logic [YW-1:0]        cur_cy;
  logic [7:0]           cur_mask;
  logic [2:0]           cur_col;
  logic signed [SW-1:0] ox, oy, crit;
  logic [2:0]           k;

  logic signed [SW-1:0] cxs, cys, px, py;
  logic signed [SW-1:0] oy_n, ox_n, crit_n;
  logic                 crit_le0, more, in_range;
  logic [AW:0]          idx_n;

  assign cxs      = $signed({{(SW-XW){1'b0}}, cur_cx});
  assign cys      = $signed({{(SW-YW){1'b0}}, cur_cy});
  assign oy_n     = oy + ONE;
  assign crit_le0 = crit[SW-1] || (crit == '0);
  assign ox_n     = crit_le0 ? ox : ox - ONE;
  assign crit_n   = crit_le0 ? crit + (oy_n <<< 1) + ONE
                             : crit + ((oy_n - ox_n) <<< 1) + ONE;
  assign more     = (oy_n <= ox_n);
  assign idx_n    = idx + 1'b1;
  assign in_range = !px[SW-1] && (px < LIM_X) && !py[SW-1] && (py < LIM_Y);

  // Octant point for the current sub-step
  always_comb begin
    px = cxs + ox;
    py = cys + oy;
    case (k)
      3'd0: begin px = cxs + ox; py = cys + oy; end
      3'd1: begin px = cxs + oy; py = cys + ox; end
      3'd2: begin px = cxs - oy; py = cys + ox; end
      3'd3: begin px = cxs - ox; py = cys + oy; end
      3'd4: begin px = cxs - ox; py = cys - oy; end
      3'd5: begin px = cxs - oy; py = cys - ox; end
      3'd6: begin px = cxs + oy; py = cys - ox; end
      default: begin px = cxs + ox; py = cys - oy; end
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  // Next state and Moore outputs
  always_comb begin
    nstate     = state;
    vga_x      = '0;
    vga_y      = '0;
    vga_colour = '0;
    vga_plot   = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) nstate = LOAD;
      end
      LOAD: begin
        if (clr_q)              nstate = CLEAR;
        else if (count != '0)   nstate = ARC_INIT;
        else                    nstate = DONE;
      end
      CLEAR: begin
        vga_x      = sx;
        vga_y      = sy;
        vga_colour = BG_COLOUR;
        vga_plot   = 1'b1;
        if (sx == LAST_X && sy == LAST_Y)
          nstate = (count != '0) ? ARC_INIT : DONE;
      end
      ARC_INIT: nstate = ARC_RUN;
      ARC_RUN: begin
        vga_x      = px[XW-1:0];
        vga_y      = py[YW-1:0];
        vga_colour = cur_col;
        vga_plot   = cur_mask[k] && in_range;
        if (k == 3'd7 && !more)
          nstate = (idx_n < count) ? ARC_INIT : DONE;
      end
      DONE: begin
        busy = 1'b0;
        done = 1'b1;
        if (!start) nstate = IDLE;
      end
      default: nstate = IDLE;
    endcase
  end

  // Descriptor writes, accepted only while the engine is idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < N_ARCS; j++) begin
        tab_cx[j]   <= '0;
        tab_cy[j]   <= '0;
        tab_r[j]    <= '0;
        tab_mask[j] <= '0;
        tab_col[j]  <= '0;
      end
    end else if (arc_we && !busy) begin
      tab_cx[arc_addr]   <= arc_cx;
      tab_cy[arc_addr]   <= arc_cy;
      tab_r[arc_addr]    <= arc_r;
      tab_mask[arc_addr] <= arc_mask;
      tab_col[arc_addr]  <= arc_colour;
    end
  end

  // Job latch, clear sweep counters and midpoint-circle datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clr_q    <= 1'b0;
      count    <= '0;
      idx      <= '0;
      sx       <= '0;
      sy       <= '0;
      cur_cx   <= '0;
      cur_cy   <= '0;
      cur_mask <= '0;
      cur_col  <= '0;
      ox       <= '0;
      oy       <= '0;
      crit     <= '0;
      k        <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          clr_q <= clear_en;
          count <= (num_arcs > NMAX) ? NMAX : num_arcs;
          idx   <= '0;
        end
        LOAD: begin
          sx <= '0;
          sy <= '0;
        end
        CLEAR: begin
          if (sy == LAST_Y) begin
            sy <= '0;
            sx <= sx + 1'b1;
          end else begin
            sy <= sy + 1'b1;
          end
        end
        ARC_INIT: begin
          cur_cx   <= tab_cx[idx[AW-1:0]];
          cur_cy   <= tab_cy[idx[AW-1:0]];
          cur_mask <= tab_mask[idx[AW-1:0]];
          cur_col  <= tab_col[idx[AW-1:0]];
          ox       <= $signed({{(SW-RW){1'b0}}, tab_r[idx[AW-1:0]]});
          oy       <= '0;
          crit     <= ONE - $signed({{(SW-RW){1'b0}}, tab_r[idx[AW-1:0]]});
          k        <= '0;
        end
        ARC_RUN: begin
          k <= k + 1'b1;
          if (k == 3'd7) begin
            oy   <= oy_n;
            ox   <= ox_n;
            crit <= crit_n;
            if (!more) idx <= idx_n;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
